mlp_mac_relu_datapath: RTL and testbench

//  8-lane multiply-accumulate/activation datapath driven by the MLP layer controller's multStg/shift outputs.
//  Per input row, multiplies one 9-bit activation (one of 4 lanes in a 36-bit tensor word) by 8 signed 9-bit weights.
//  It accumulates across rows, then applies arithmetic right-shift, ReLU and width reduction.

---
 rtl/mlp_pkg.sv | 26 ++
 rtl/mlp_mac_relu_datapath_if.sv | 21 ++
 rtl/mlp_mac_lane.sv | 74 +++++++
 rtl/mlp_mac_relu_datapath.sv | 52 +++++
 tb/tb_mlp_mac_relu_datapath.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared MLP datapath definitions: controller stage encodings, lane geometry and slice helpers.
// The layer controller uses the same stage encodings.
package mlp_pkg;
  localparam int LANES     = 8;
  localparam int DW        = 9;
  localparam int ACC_WIDTH = 32;
  localparam int TM_LANES  = 4;

  typedef enum logic [2:0] {
    MULT_WAIT  = 3'd0,
    MULT_MULT  = 3'd1,
    MULT_ACC   = 3'd2,
    MULT_ACT   = 3'd3,
    MULT_NOACC = 3'd4
  } mult_stg_t;

  function automatic logic [DW-1:0] act_lane(input logic [TM_LANES*DW-1:0] word,
                                             input logic [1:0] idx);
    return word[idx*DW +: DW];
  endfunction

  // Reserved encodings 5-7 behave exactly like Wait.
  function automatic logic stg_is_wait(input logic [2:0] s);
    return (s == MULT_WAIT) || (s > MULT_NOACC);
  endfunction
endpackage

// File: rtl/mlp_mac_relu_datapath_if.sv
// Controller <-> MAC/ReLU datapath bus: stage control, BRAM read data and tensor write data.
interface mlp_mac_relu_datapath_if;
  logic [2:0]                                multStg;
  logic [7:0]                                shift;
  logic [mlp_pkg::LANES*mlp_pkg::DW-1:0]     wm_dout;
  logic [mlp_pkg::TM_LANES*mlp_pkg::DW-1:0]  tm_din;
  logic [1:0]                                tm_input_lane;
  logic                                      tm_output_group;
  logic [mlp_pkg::TM_LANES*mlp_pkg::DW-1:0]  tm_dout;
  logic                                      acc_ovf;

  modport master (
    output multStg, shift, wm_dout, tm_din, tm_input_lane, tm_output_group,
    input  tm_dout, acc_ovf
  );

  modport slave (
    input  multStg, shift, wm_dout, tm_din, tm_input_lane, tm_output_group,
    output tm_dout, acc_ovf
  );
endinterface

// File: rtl/mlp_mac_lane.sv
// One output neuron: 9x9 signed multiply, accumulate, arithmetic shift, ReLU, 9-bit reduction.
// MLP_SAT_EN selects saturating accumulate / clamped reduction; otherwise wrap / truncate.
module mlp_mac_lane #(
  parameter int ACC_WIDTH = mlp_pkg::ACC_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [2:0]             stg,
  input  logic [mlp_pkg::DW-1:0] weight,
  input  logic [mlp_pkg::DW-1:0] act,
  input  logic [7:0]             shift,
  output logic [mlp_pkg::DW-1:0] res,
  output logic                   ovf
);
  import mlp_pkg::*;

  localparam int PW = 2*DW;
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, t, r;
  logic        [SW-1:0]        sum;
  logic        [DW-1:0]        red;
  logic                        add_ovf;

  // Sum one bit wider than either operand so overflow is visible as disagreeing upper bits.
  always_comb begin
    sum     = {{(SW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc} + {{(SW-PW){prod[PW-1]}}, prod};
    add_ovf = !((&sum[SW-1:ACC_WIDTH-1]) || !(|sum[SW-1:ACC_WIDTH-1]));
`ifdef MLP_SAT_EN
    if (add_ovf)
      acc_nxt = sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      acc_nxt = sum[ACC_WIDTH-1:0];
`else
    acc_nxt = sum[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    if (int'(shift) >= ACC_WIDTH) t = {ACC_WIDTH{acc[ACC_WIDTH-1]}};
    else                          t = acc >>> shift;
    r = t[ACC_WIDTH-1] ? '0 : t;
`ifdef MLP_SAT_EN
    red = (|r[ACC_WIDTH-1:DW-1]) ? {1'b0, {(DW-1){1'b1}}} : r[DW-1:0];
`else
    red = r[DW-1:0];
`endif
  end

  assign ovf = (stg == MULT_ACC) && add_ovf;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prod <= '0;
      acc  <= '0;
      res  <= '0;
    end else begin
      case (stg)
        MULT_MULT:  prod <= $signed({{DW{weight[DW-1]}}, weight}) * $signed({{DW{act[DW-1]}}, act});
        MULT_NOACC: begin
          prod <= $signed({{DW{weight[DW-1]}}, weight}) * $signed({{DW{act[DW-1]}}, act});
          acc  <= '0;
        end
        MULT_ACC:   acc <= acc_nxt;
        MULT_ACT:   begin
          res <= red;
          acc <= '0;
        end
        default:    acc <= '0;
      endcase
    end
  end
endmodule

// File: rtl/mlp_mac_relu_datapath.sv
// 8-lane MAC/ReLU datapath behind the MLP layer controller; stage/lane aligned to BRAM read latency.
// MLP_SAT_EN (lane level) switches accumulate/reduction from wrap/truncate to saturate/clamp.
module mlp_mac_relu_datapath #(
  parameter int ACC_WIDTH = mlp_pkg::ACC_WIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  mlp_mac_relu_datapath_if.slave bus
);
  import mlp_pkg::*;

  logic [2:0]                stg_d;
  logic [1:0]                lane_d;
  logic [DW-1:0]             act;
  logic [LANES-1:0]          lane_ovf;
  logic [LANES-1:0][DW-1:0]  res;
  logic                      ovf_q;

  // BRAM data arrives one cycle after the controller issues stage and address.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stg_d  <= MULT_WAIT;
      lane_d <= '0;
      ovf_q  <= 1'b0;
    end else begin
      stg_d  <= bus.multStg;
      lane_d <= bus.tm_input_lane;
      if (|lane_ovf)
        ovf_q <= 1'b1;
      else if (stg_is_wait(stg_d) && bus.multStg == MULT_MULT)
        ovf_q <= 1'b0;
    end
  end

  assign act = act_lane(bus.tm_din, lane_d);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mlp_mac_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .stg    (stg_d),
      .weight (bus.wm_dout[k*DW +: DW]),
      .act    (act),
      .shift  (bus.shift),
      .res    (res[k]),
      .ovf    (lane_ovf[k])
    );
  end

  assign bus.tm_dout = bus.tm_output_group ? res[7:4] : res[3:0];
  assign bus.acc_ovf = ovf_q;
endmodule

// File: tb/tb_mlp_mac_relu_datapath.sv
// Directed bench: 32-bit accumulator DUT plus a 16-bit one sharing stimulus for overflow cases.
module tb_mlp_mac_relu_datapath;
  logic clk, resetn;
  int   checks, errors;
  logic [71:0] w_pend, w;
  logic [35:0] x_pend, x;

  mlp_mac_relu_datapath_if bus ();
  mlp_mac_relu_datapath_if bus16 ();

  assign bus16.multStg         = bus.multStg;
  assign bus16.shift           = bus.shift;
  assign bus16.wm_dout         = bus.wm_dout;
  assign bus16.tm_din          = bus.tm_din;
  assign bus16.tm_input_lane   = bus.tm_input_lane;
  assign bus16.tm_output_group = bus.tm_output_group;

  mlp_mac_relu_datapath u_dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  mlp_mac_relu_datapath #(.ACC_WIDTH(16)) u_dut16 (.clk(clk), .resetn(resetn), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stage/lane go out now; the row data follows one cycle later, like the BRAM.
  task automatic drive(input logic [2:0] stg, input logic [1:0] lane,
                       input logic [71:0] wd, input logic [35:0] xd);
    bus.multStg       = stg;
    bus.tm_input_lane = lane;
    bus.wm_dout       = w_pend;
    bus.tm_din        = x_pend;
    w_pend = wd;
    x_pend = xd;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'd0, 2'd0, '0, '0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.multStg = 3'($urandom_range(0, 7));
      bus.shift = 8'($urandom);
      bus.wm_dout = {$urandom, $urandom, $urandom};
      bus.tm_din = {$urandom, $urandom};
      bus.tm_input_lane = 2'($urandom);
      bus.tm_output_group = 1'($urandom);
      tick();
    end
    bus.tm_output_group = 1'b0; #1;
    checks++; if (bus.tm_dout !== 36'd0) begin errors++; $display("FAIL reset_g0 got %h want 0", bus.tm_dout); end
    bus.tm_output_group = 1'b1; #1;
    checks++; if (bus.tm_dout !== 36'd0) begin errors++; $display("FAIL reset_g1 got %h want 0", bus.tm_dout); end
    checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.acc_ovf); end
    checks++; if (bus16.acc_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf16 got %b want 0", bus16.acc_ovf); end
    w_pend = '0; x_pend = '0; bus.tm_output_group = 1'b0;
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_two_rows();
    logic [71:0] w1, w2;
    logic [35:0] x1, x2;
    bus.shift = 8'd0;
    w1 = '0; w1[8:0] = 9'd3;      w1[17:9] = 9'd1;
    w2 = '0; w2[8:0] = 9'h1FE;    w2[17:9] = 9'd1;
    x1 = {9'd7, 9'd5, 9'd9, 9'd11};
    x2 = {9'd7, 9'd6, 9'd4, 9'd11};
    drive(3'd1, 2'd2, w1, x1);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd1, 2'd1, w2, x2);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    bus.tm_output_group = 1'b0; #1;
    checks++; if (bus.tm_dout !== {9'd0, 9'd0, 9'd9, 9'd7}) begin errors++; $display("FAIL two_rows got %h want %h", bus.tm_dout, {9'd0, 9'd0, 9'd9, 9'd7}); end
  endtask

  task automatic test_relu_shift();
    bus.shift = 8'd2;
    w = '0; w[44:36] = 9'd20; w[53:45] = 9'h1F8;
    x = {9'd0, 9'd0, 9'd0, 9'd5};
    drive(3'd1, 2'd0, w, x);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    bus.tm_output_group = 1'b1; #1;
    checks++; if (bus.tm_dout !== {9'd0, 9'd0, 9'd0, 9'd25}) begin errors++; $display("FAIL relu_g1 got %h want %h", bus.tm_dout, {9'd0, 9'd0, 9'd0, 9'd25}); end
    bus.tm_output_group = 1'b0; #1;
    checks++; if (bus.tm_dout !== 36'd0) begin errors++; $display("FAIL relu_g0 got %h want 0", bus.tm_dout); end
  endtask

  task automatic test_noacc();
    bus.shift = 8'd0;
    w = '0; w[8:0] = 9'd20;
    x = {9'd25, 9'd0, 9'd0, 9'd0};
    drive(3'd1, 2'd3, w, x);
    drive(3'd2, 2'd0, '0, '0);
    w = '0; w[8:0] = 9'd1;
    x = {9'd0, 9'd0, 9'd0, 9'd1};
    drive(3'd4, 2'd0, w, x);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    checks++; if (bus.tm_dout !== 36'd1) begin errors++; $display("FAIL noacc got %0d want 1", bus.tm_dout); end
  endtask

  task automatic test_saturation();
    bus.shift = 8'd0;
    w = '0; w[8:0] = 9'd255;
    x = {9'd0, 9'd0, 9'd0, 9'd255};
    for (int i = 0; i < 255; i++) begin
      drive(3'd1, 2'd0, w, x);
      drive(3'd2, 2'd0, '0, '0);
    end
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    checks++; if (bus.tm_dout !== 36'd255) begin errors++; $display("FAIL sat32_res got %0d want 255", bus.tm_dout); end
    checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL sat32_ovf got %b want 0", bus.acc_ovf); end
    checks++; if (bus16.tm_dout !== 36'd255) begin errors++; $display("FAIL sat16_res got %0d want 255", bus16.tm_dout); end
    checks++; if (bus16.acc_ovf !== 1'b1) begin errors++; $display("FAIL sat16_ovf got %b want 1", bus16.acc_ovf); end
  endtask

  task automatic test_ovf_clear();
    drive(3'd1, 2'd0, '0, '0);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    checks++; if (bus16.acc_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus16.acc_ovf); end
  endtask

  task automatic test_shift_bound();
    w = '0; w[8:0] = 9'd10;
    x = {9'd0, 9'd0, 9'd0, 9'd30};
    bus.shift = 8'd40;
    drive(3'd1, 2'd0, w, x);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    checks++; if (bus.tm_dout !== 36'd0) begin errors++; $display("FAIL shift40 got %0d want 0", bus.tm_dout); end
    bus.shift = 8'd8;
    drive(3'd1, 2'd0, w, x);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    checks++; if (bus.tm_dout !== 36'd1) begin errors++; $display("FAIL shift8 got %0d want 1", bus.tm_dout); end
  endtask

  task automatic test_mid_reset();
    bus.shift = 8'd0;
    w = '0; w[8:0] = 9'd10;
    x = {9'd0, 9'd0, 9'd0, 9'd10};
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 2'd0, w, x);
      drive(3'd2, 2'd0, '0, '0);
    end
    resetn = 1'b0;
    drive(3'd0, 2'd0, '0, '0);
    checks++; if (bus.tm_dout !== 36'd0) begin errors++; $display("FAIL midrst_res got %0d want 0", bus.tm_dout); end
    resetn = 1'b1;
    idle(2);
    w = '0; w[8:0] = 9'd2;
    x = {9'd0, 9'd0, 9'd0, 9'd3};
    drive(3'd1, 2'd0, w, x);
    drive(3'd2, 2'd0, '0, '0);
    drive(3'd3, 2'd0, '0, '0);
    idle(2);
    checks++; if (bus.tm_dout !== 36'd6) begin errors++; $display("FAIL midrst_new got %0d want 6", bus.tm_dout); end
  endtask

  initial begin
    checks = 0; errors = 0;
    w_pend = '0; x_pend = '0; w = '0; x = '0;
    resetn = 1'b0;
    bus.multStg = 3'd0; bus.shift = 8'd0; bus.wm_dout = '0; bus.tm_din = '0;
    bus.tm_input_lane = 2'd0; bus.tm_output_group = 1'b0;
    test_reset();
    test_two_rows();
    test_relu_shift();
    test_noacc();
    test_saturation();
    test_ovf_clear();
    test_shift_bound();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
